buf_wr_dispatch: RTL and testbench

Sink end of the execute-stage buffer-write interface. It accepts the post-pipeline write requests (6-bit namespace request mask, packed base/stride address, data) and queues them in a small FIFO. Each queued write is issued to the namespace buffer banks only when every targeted bank is ready. It sits between the execute control pipelines and the six namespace buffer write ports, and reports occupancy, overflow and write-count status.

---
 rtl/buf_wr_dispatch_pkg.sv | 21 ++
 rtl/buf_wr_fifo.sv | 66 ++++++
 rtl/buf_wr_dispatch.sv | 111 +++++++++++
 tb/tb_buf_wr_dispatch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/buf_wr_dispatch_pkg.sv
// Shared types for the execute-stage buffer-write path.
// Imported by the dispatch block and the execute control pipelines.
package buf_wr_dispatch_pkg;

    localparam int NUM_NS            = 6;
    localparam int NS_ID_BITS        = 3;
    localparam int NS_INDEX_ID_BITS  = 5;
    localparam int BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS);
    localparam int BUF_ADDR_BITS     = 10;
    localparam int DATA_WIDTH        = 32;
    localparam int FIFO_DEPTH        = 4;
    localparam int PTR_BITS          = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS          = PTR_BITS + 1;

    typedef struct packed {
        logic [NUM_NS-1:0]        req;
        logic [BUF_ADDR_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wr_entry_t;

endpackage

// File: rtl/buf_wr_fifo.sv
// Small synchronous queue of pending buffer writes.
// Caller guarantees no push while full unless popping in the same cycle.
module buf_wr_fifo
    import buf_wr_dispatch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  wr_entry_t                    wdata_i,
    output wr_entry_t                    rdata_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);

    wr_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     level_q, level_d;

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && !pop_i)
            level_d = level_q + (PW+1)'(1);
        else if (!push_i && pop_i)
            level_d = level_q - (PW+1)'(1);
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/buf_wr_dispatch.sv
// Queues execute-stage buffer writes and issues each one
// to the namespace banks once all of its target banks are ready.
module buf_wr_dispatch
    import buf_wr_dispatch_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_NS-1:0]            buf_wr_req_in,
    input  logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in,
    input  logic [DATA_WIDTH-1:0]        buf_wr_data_in,
    input  logic [NUM_NS-1:0]            ns_wr_ready,
    input  logic                         clr_err,
    output logic [NUM_NS-1:0]            ns_wr_en,
    output logic [BUF_ADDR_BITS-1:0]     ns_wr_addr,
    output logic [DATA_WIDTH-1:0]        ns_wr_data,
    output logic [LVL_BITS-1:0]          fifo_level,
    output logic                         fifo_full,
    output logic                         ovf_err,
    output logic [15:0]                  wr_count
);

    wr_entry_t in_entry;
    wr_entry_t head;
    logic      req_vld;
    logic      empty;
    logic      full;
    logic      issue;
    logic      push;
    logic      drop;
    logic      unused_addr_hi;

    logic [NUM_NS-1:0]        en_q;
    logic [BUF_ADDR_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [15:0]              cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    // Only the low address bits reach the bank address port.
    assign unused_addr_hi =
        ^buf_wr_addr_in[BASE_STRIDE_WIDTH-1:BUF_ADDR_BITS];

    assign in_entry.req  = buf_wr_req_in;
    assign in_entry.addr = buf_wr_addr_in[BUF_ADDR_BITS-1:0];
    assign in_entry.data = buf_wr_data_in;

    assign req_vld = |buf_wr_req_in;
    // Head waits until every targeted bank is ready; others are ignored.
    assign issue   = !empty && ((ns_wr_ready & head.req) == head.req);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push    = req_vld && (!full || issue);
    assign drop    = req_vld && full && !issue;

    buf_wr_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i (in_entry),
        .rdata_o (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );

    // Next-state for issue counter and sticky overflow; drop beats clear.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (issue) cnt_d = cnt_q + 16'd1;
        if (drop)
            ovf_d = 1'b1;
        else if (clr_err)
            ovf_d = 1'b0;
    end

    // Registered bank strobe; address/data hold between issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= issue ? head.req : '0;
            if (issue) begin
                addr_q <= head.addr;
                data_q <= head.data;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ns_wr_en   = en_q;
    assign ns_wr_addr = addr_q;
    assign ns_wr_data = data_q;
    assign fifo_full  = full;
    assign ovf_err    = ovf_q;
    assign wr_count   = cnt_q;

endmodule

// File: tb/tb_buf_wr_dispatch.sv
// Scoreboard bench for buf_wr_dispatch: directed stimulus queues
// expected bank writes, a monitor pops them as strobes appear.
module tb_buf_wr_dispatch;
    import buf_wr_dispatch_pkg::*;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic [NUM_NS-1:0]            buf_wr_req_in = '0;
    logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in = '0;
    logic [DATA_WIDTH-1:0]        buf_wr_data_in = '0;
    logic [NUM_NS-1:0]            ns_wr_ready = '0;
    logic                         clr_err = 1'b0;
    logic [NUM_NS-1:0]            ns_wr_en;
    logic [BUF_ADDR_BITS-1:0]     ns_wr_addr;
    logic [DATA_WIDTH-1:0]        ns_wr_data;
    logic [LVL_BITS-1:0]          fifo_level;
    logic                         fifo_full;
    logic                         ovf_err;
    logic [15:0]                  wr_count;

    int n_checks = 0;
    int n_pass   = 0;
    wr_entry_t exp_q [$];

    buf_wr_dispatch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .buf_wr_req_in  (buf_wr_req_in),
        .buf_wr_addr_in (buf_wr_addr_in),
        .buf_wr_data_in (buf_wr_data_in),
        .ns_wr_ready    (ns_wr_ready),
        .clr_err        (clr_err),
        .ns_wr_en       (ns_wr_en),
        .ns_wr_addr     (ns_wr_addr),
        .ns_wr_data     (ns_wr_data),
        .fifo_level     (fifo_level),
        .fifo_full      (fifo_full),
        .ovf_err        (ovf_err),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one request for one edge; queue it if it should be written.
    task automatic send(input logic [5:0] r, input logic [31:0] a,
                        input logic [31:0] d, input bit keep);
        wr_entry_t e;
        buf_wr_req_in  = r;
        buf_wr_addr_in = a;
        buf_wr_data_in = d;
        if (keep) begin
            e.req  = r;
            e.addr = a[BUF_ADDR_BITS-1:0];
            e.data = d;
            exp_q.push_back(e);
        end
        tick();
        buf_wr_req_in = '0;
    endtask

    // Monitor: every strobe must match the oldest expected write.
    initial begin
        wr_entry_t e;
        forever begin
            @(negedge clk);
            if (ns_wr_en !== '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: got en=%b addr=%0h data=%0h required none",
                             ns_wr_en, ns_wr_addr, ns_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ns_wr_en === e.req && ns_wr_addr === e.addr
                        && ns_wr_data === e.data)
                        n_pass++;
                    else
                        $display("FAIL strobe: got en=%b addr=%0h data=%0h required en=%b addr=%0h data=%0h",
                                 ns_wr_en, ns_wr_addr, ns_wr_data,
                                 e.req, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        chk("rst_en", 32'(ns_wr_en), 0);
        chk("rst_addr", 32'(ns_wr_addr), 0);
        chk("rst_data", ns_wr_data, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_cnt", 32'(wr_count), 0);
        reset_n = 1'b1;
        ns_wr_ready = '1;
        tick();

        // Basic write: two-cycle latency, low address bits only
        send(6'b000100, 32'h12345678, 32'hDEADBEEF, 1);
        chk("s1_level", 32'(fifo_level), 1);
        chk("s1_noearly", 32'(ns_wr_en), 0);
        tick();
        chk("s1_en", 32'(ns_wr_en), 32'h04);
        chk("s1_addr", 32'(ns_wr_addr), 32'h278);
        chk("s1_data", ns_wr_data, 32'hDEADBEEF);
        chk("s1_cnt", 32'(wr_count), 1);
        chk("s1_empty", 32'(fifo_level), 0);
        repeat (3) tick();
        chk("s1_hold_addr", 32'(ns_wr_addr), 32'h278);

        // Multi-bank stall until bank 5 ready
        ns_wr_ready = 6'b011111;
        send(6'b100001, 32'h0000_0155, 32'hA5A5_0001, 1);
        tick();
        tick();
        chk("s2_stall_en", 32'(ns_wr_en), 0);
        chk("s2_stall_lvl", 32'(fifo_level), 1);
        ns_wr_ready = '1;
        tick();
        chk("s2_en", 32'(ns_wr_en), 32'h21);
        chk("s2_cnt", 32'(wr_count), 2);
        ns_wr_ready = 6'b000001;
        send(6'b100001, 32'hFFFF_F3FF, 32'hA5A5_0002, 1);
        repeat (3) tick();
        chk("s2b_stall_en", 32'(ns_wr_en), 0);
        chk("s2b_stall_lvl", 32'(fifo_level), 1);
        ns_wr_ready = '1;
        tick();
        tick();
        chk("s2b_drained", 32'(fifo_level), 0);

        // Overflow: fifth request lost
        ns_wr_ready = '0;
        send(6'b000001, 32'h0000_0010, 32'h1111_0001, 1);
        send(6'b000010, 32'h0000_0020, 32'h1111_0002, 1);
        send(6'b000100, 32'h0000_0030, 32'h1111_0003, 1);
        send(6'b001000, 32'h0000_0040, 32'h1111_0004, 1);
        chk("s3_ovf_pre", 32'(ovf_err), 0);
        send(6'b010000, 32'h0000_0050, 32'h1111_0005, 0);
        chk("s3_level", 32'(fifo_level), 4);
        chk("s3_full", 32'(fifo_full), 1);
        chk("s3_ovf", 32'(ovf_err), 1);
        ns_wr_ready = '1;
        repeat (6) tick();
        chk("s3_drained", 32'(fifo_level), 0);
        chk("s3_notfull", 32'(fifo_full), 0);
        chk("s3_sticky", 32'(ovf_err), 1);
        chk("s3_cnt", 32'(wr_count), 7);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("s3_clr", 32'(ovf_err), 0);

        // Full with simultaneous pop: push accepted
        ns_wr_ready = '0;
        send(6'b000001, 32'h0000_0101, 32'h2222_0001, 1);
        send(6'b000001, 32'h0000_0102, 32'h2222_0002, 1);
        send(6'b000001, 32'h0000_0103, 32'h2222_0003, 1);
        send(6'b000001, 32'h0000_0104, 32'h2222_0004, 1);
        chk("s4_full", 32'(fifo_full), 1);
        ns_wr_ready = '1;
        send(6'b000001, 32'h0000_0105, 32'h2222_0005, 1);
        chk("s4_level", 32'(fifo_level), 4);
        chk("s4_ovf", 32'(ovf_err), 0);
        chk("s4_en", 32'(ns_wr_en), 32'h01);
        repeat (6) tick();
        chk("s4_drained", 32'(fifo_level), 0);

        // Head blocking: A waits on bank1, B must wait behind it
        ns_wr_ready = 6'b111101;
        send(6'b000010, 32'h0000_0201, 32'h3333_000A, 1);
        send(6'b000100, 32'h0000_0202, 32'h3333_000B, 1);
        tick();
        chk("s5_block_en", 32'(ns_wr_en), 0);
        chk("s5_block_lvl", 32'(fifo_level), 2);
        ns_wr_ready = '1;
        tick();
        chk("s5_a", 32'(ns_wr_en), 32'h02);
        tick();
        chk("s5_b", 32'(ns_wr_en), 32'h04);
        tick();
        chk("s5_drained", 32'(fifo_level), 0);

        // Async reset mid-stream discards queued entries
        ns_wr_ready = '0;
        send(6'b000001, 32'h0000_0301, 32'h4444_0001, 0);
        send(6'b000010, 32'h0000_0302, 32'h4444_0002, 0);
        send(6'b000100, 32'h0000_0303, 32'h4444_0003, 0);
        chk("s6_level", 32'(fifo_level), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_addr", 32'(ns_wr_addr), 0);
        chk("s6_data", ns_wr_data, 0);
        chk("s6_level0", 32'(fifo_level), 0);
        chk("s6_cnt", 32'(wr_count), 0);
        tick();
        reset_n = 1'b1;
        ns_wr_ready = '1;
        repeat (3) tick();
        chk("s6_post_en", 32'(ns_wr_en), 0);
        chk("s6_post_cnt", 32'(wr_count), 0);

        // Counter wrap from a preloaded value
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        send(6'b001000, 32'h0000_03FF, 32'h5555_0001, 1);
        tick();
        chk("s7_en", 32'(ns_wr_en), 32'h08);
        chk("s7_wrap", 32'(wr_count), 0);
        repeat (2) tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
